// File: rtl/r4_bin_collector_if.sv
// Readout stream of the radix-4 bin collector: one buffered bin per valid/ready beat.
// The out_mag_o field exists only when R4_COLLECT_MAG_EN is defined.
interface r4_bin_collector_if #(
    parameter int DW = 4
);
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_re_o;
    logic [DW-1:0] out_im_o;
    logic [1:0]    out_idx_o;
    logic          out_last_o;
`ifdef R4_COLLECT_MAG_EN
    logic [DW:0]   out_mag_o;
`endif

    modport master (
        input  out_ready_i,
        output out_valid_o, out_re_o, out_im_o, out_idx_o, out_last_o
`ifdef R4_COLLECT_MAG_EN
        , out_mag_o
`endif
    );

    modport slave (
        output out_ready_i,
        input  out_valid_o, out_re_o, out_im_o, out_idx_o, out_last_o
`ifdef R4_COLLECT_MAG_EN
        , out_mag_o
`endif
    );
endinterface

// File: rtl/r4_bin_collector.sv
// Steps the radix-4 butterfly bin select through bins 0..3, captures each bin into a
// 4-entry frame buffer and drains it over a valid/ready stream. R4_COLLECT_MAG_EN adds |re|+|im|.
module r4_bin_collector #(
    parameter int DW     = 4,
    parameter int SETTLE = 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,
    input  logic          start_i,
    input  logic          clr_i,
    input  logic [DW-1:0] xr_i,
    input  logic [DW-1:0] xi_i,
    output logic [2:0]    ctrl_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          overrun_o,
    r4_bin_collector_if.master out_if
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    // Butterfly select is one-hot above bin 0: {c3,c2,c1}.
    function automatic logic [2:0] bin_ctrl(input logic [1:0] bin);
        case (bin)
            2'd0:    bin_ctrl = 3'b000;
            2'd1:    bin_ctrl = 3'b001;
            2'd2:    bin_ctrl = 3'b010;
            2'd3:    bin_ctrl = 3'b100;
            default: bin_ctrl = 3'b000;
        endcase
    endfunction

`ifdef R4_COLLECT_MAG_EN
    // Sign-extend first so that the most negative value maps to +2^(DW-1).
    function automatic logic [DW:0] abs_ext(input logic [DW-1:0] v);
        logic [DW:0] e;
        e = {v[DW-1], v};
        if (v[DW-1]) begin
            abs_ext = ~e + {{DW{1'b0}}, 1'b1};
        end else begin
            abs_ext = e;
        end
    endfunction

    logic [DW:0] mag_buf_r [0:3];
    logic [DW:0] mag_r;
    logic [DW:0] mag_nxt_s;
`endif

    state_t        state_r, state_nxt_s;
    logic [1:0]    bin_r, bin_nxt_s;
    logic [3:0]    cnt_r, cnt_nxt_s;
    logic [1:0]    rd_ptr_r, rd_ptr_nxt_s;
    logic [DW-1:0] re_buf_r [0:3];
    logic [DW-1:0] im_buf_r [0:3];
    logic          cap_s, hs_s, last_hs_s, reject_s;

    logic [2:0]    ctrl_r, ctrl_nxt_s;
    logic          busy_r, valid_r, last_r, done_r, overrun_r;
    logic          valid_nxt_s, last_nxt_s, overrun_nxt_s;
    logic [DW-1:0] re_r, im_r, re_nxt_s, im_nxt_s;
    logic [1:0]    idx_r, idx_nxt_s;

    // Next-state logic: bin stepping, capture strobe, drain pointer and start rejection.
    always_comb begin
        state_nxt_s  = state_r;
        bin_nxt_s    = bin_r;
        cnt_nxt_s    = cnt_r;
        rd_ptr_nxt_s = rd_ptr_r;
        cap_s        = 1'b0;
        reject_s     = 1'b0;
        hs_s         = valid_r & out_if.out_ready_i;
        last_hs_s    = hs_s & (rd_ptr_r == 2'd3);
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = ST_SETTLE;
                    bin_nxt_s   = 2'd0;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                reject_s = start_i;
                if (cnt_r == SETTLE_LAST) begin
                    cap_s     = 1'b1;
                    cnt_nxt_s = 4'd0;
                    if (bin_r == 2'd3) begin
                        state_nxt_s  = ST_DRAIN;
                        rd_ptr_nxt_s = 2'd0;
                    end else begin
                        bin_nxt_s = bin_r + 2'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
            ST_DRAIN: begin
                // A start landing on the final handshake chains straight into the next frame.
                reject_s = start_i & ~last_hs_s;
                if (last_hs_s) begin
                    if (start_i) begin
                        state_nxt_s = ST_SETTLE;
                        bin_nxt_s   = 2'd0;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (hs_s) begin
                    rd_ptr_nxt_s = rd_ptr_r + 2'd1;
                end else begin
                    rd_ptr_nxt_s = rd_ptr_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered output values derived from the next state so outputs align with the state.
    always_comb begin
        ctrl_nxt_s  = 3'b000;
        valid_nxt_s = 1'b0;
        re_nxt_s    = {DW{1'b0}};
        im_nxt_s    = {DW{1'b0}};
        idx_nxt_s   = 2'd0;
        last_nxt_s  = 1'b0;
`ifdef R4_COLLECT_MAG_EN
        mag_nxt_s   = {(DW+1){1'b0}};
`endif
        if (state_nxt_s == ST_SETTLE) begin
            ctrl_nxt_s = bin_ctrl(bin_nxt_s);
        end else if (state_nxt_s == ST_DRAIN) begin
            valid_nxt_s = 1'b1;
            re_nxt_s    = re_buf_r[rd_ptr_nxt_s];
            im_nxt_s    = im_buf_r[rd_ptr_nxt_s];
            idx_nxt_s   = rd_ptr_nxt_s;
            last_nxt_s  = (rd_ptr_nxt_s == 2'd3);
`ifdef R4_COLLECT_MAG_EN
            mag_nxt_s   = mag_buf_r[rd_ptr_nxt_s];
`endif
        end else begin
            ctrl_nxt_s = 3'b000;
        end
        if (reject_s) begin
            overrun_nxt_s = 1'b1;
        end else if (clr_i) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // FSM state, bin/settle counters and drain pointer.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_r  <= ST_IDLE;
            bin_r    <= 2'd0;
            cnt_r    <= 4'd0;
            rd_ptr_r <= 2'd0;
        end else begin
            state_r  <= state_nxt_s;
            bin_r    <= bin_nxt_s;
            cnt_r    <= cnt_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
        end
    end

    // Frame buffer; only written by captures, so it stays frozen while draining.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                re_buf_r[i] <= {DW{1'b0}};
                im_buf_r[i] <= {DW{1'b0}};
`ifdef R4_COLLECT_MAG_EN
                mag_buf_r[i] <= {(DW+1){1'b0}};
`endif
            end
        end else if (cap_s) begin
            re_buf_r[bin_r] <= xr_i;
            im_buf_r[bin_r] <= xi_i;
`ifdef R4_COLLECT_MAG_EN
            mag_buf_r[bin_r] <= abs_ext(xr_i) + abs_ext(xi_i);
`endif
        end
    end

    // Output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ctrl_r    <= 3'b000;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            re_r      <= {DW{1'b0}};
            im_r      <= {DW{1'b0}};
            idx_r     <= 2'd0;
            last_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
`ifdef R4_COLLECT_MAG_EN
            mag_r     <= {(DW+1){1'b0}};
`endif
        end else begin
            ctrl_r    <= ctrl_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            valid_r   <= valid_nxt_s;
            re_r      <= re_nxt_s;
            im_r      <= im_nxt_s;
            idx_r     <= idx_nxt_s;
            last_r    <= last_nxt_s;
            done_r    <= last_hs_s;
            overrun_r <= overrun_nxt_s;
`ifdef R4_COLLECT_MAG_EN
            mag_r     <= mag_nxt_s;
`endif
        end
    end

    assign ctrl_o             = ctrl_r;
    assign busy_o             = busy_r;
    assign frame_done_o       = done_r;
    assign overrun_o          = overrun_r;
    assign out_if.out_valid_o = valid_r;
    assign out_if.out_re_o    = re_r;
    assign out_if.out_im_o    = im_r;
    assign out_if.out_idx_o   = idx_r;
    assign out_if.out_last_o  = last_r;
`ifdef R4_COLLECT_MAG_EN
    assign out_if.out_mag_o   = mag_r;
`endif

endmodule

// File: tb/tb_r4_bin_collector.sv
// Scoreboard bench for r4_bin_collector: SETTLE=1 instance for most scenarios, SETTLE=3 instance
// for the settle-window timing. Magnitude checks compile in when R4_COLLECT_MAG_EN is defined.
module tb_r4_bin_collector;
    localparam int DW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1_n, start1, clr1, busy1, done1, ovr1;
    logic [3:0] xr1, xi1;
    logic [2:0] ctrl1;
    logic       rst3_n, start3, clr3, busy3, done3, ovr3;
    logic [3:0] xr3, xi3;
    logic [2:0] ctrl3;

    r4_bin_collector_if #(.DW(DW)) if1 ();
    r4_bin_collector_if #(.DW(DW)) if3 ();

    r4_bin_collector #(.DW(DW), .SETTLE(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_n(rst1_n), .start_i(start1), .clr_i(clr1),
        .xr_i(xr1), .xi_i(xi1), .ctrl_o(ctrl1), .busy_o(busy1),
        .frame_done_o(done1), .overrun_o(ovr1), .out_if(if1.master));

    r4_bin_collector #(.DW(DW), .SETTLE(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_n(rst3_n), .start_i(start3), .clr_i(clr3),
        .xr_i(xr3), .xi_i(xi3), .ctrl_o(ctrl3), .busy_o(busy3),
        .frame_done_o(done3), .overrun_o(ovr3), .out_if(if3.master));

    // Butterfly model: per-bin values selected by the control word.
    logic signed [3:0] m_re [4];
    logic signed [3:0] m_im [4];

    always_comb begin
        case (ctrl1)
            3'b000:  begin xr1 = m_re[0]; xi1 = m_im[0]; end
            3'b001:  begin xr1 = m_re[1]; xi1 = m_im[1]; end
            3'b010:  begin xr1 = m_re[2]; xi1 = m_im[2]; end
            3'b100:  begin xr1 = m_re[3]; xi1 = m_im[3]; end
            default: begin xr1 = 4'b0101; xi1 = 4'b1010; end
        endcase
    end

    always_comb begin
        case (ctrl3)
            3'b000:  begin xr3 = m_re[0]; xi3 = m_im[0]; end
            3'b001:  begin xr3 = m_re[1]; xi3 = m_im[1]; end
            3'b010:  begin xr3 = m_re[2]; xi3 = m_im[2]; end
            3'b100:  begin xr3 = m_re[3]; xi3 = m_im[3]; end
            default: begin xr3 = 4'b0101; xi3 = 4'b1010; end
        endcase
    end

    typedef struct packed {
        logic [3:0] re;
        logic [3:0] im;
        logic [1:0] idx;
        logic [4:0] mag;
    } beat_t;

    beat_t sb_q [$];
    int checks, errors;
    logic [2:0] ctrl_tab [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default();
        m_re[0] = 4'sd3;  m_im[0] = -4'sd1;
        m_re[1] = -4'sd8; m_im[1] = 4'sd7;
        m_re[2] = 4'sd0;  m_im[2] = 4'sd5;
        m_re[3] = 4'sd7;  m_im[3] = -4'sd8;
    endtask

    task automatic push_frame();
        beat_t b;
        int a, c;
        for (int k = 0; k < 4; k++) begin
            a = m_re[k];
            c = m_im[k];
            b.re  = m_re[k];
            b.im  = m_im[k];
            b.idx = 2'(k);
            b.mag = 5'((a < 0 ? -a : a) + (c < 0 ? -c : c));
            sb_q.push_back(b);
        end
    endtask

    // Pops the scoreboard for a dut1 beat being accepted at the coming edge.
    task automatic check_beat1(input string name, inout int beats);
        beat_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected beat idx=%0d, required no beat", name, if1.out_idx_o);
        end else begin
            e = sb_q.pop_front();
            if (if1.out_re_o !== e.re || if1.out_im_o !== e.im || if1.out_idx_o !== e.idx ||
                if1.out_last_o !== (e.idx == 2'd3)) begin
                errors++;
                $display("FAIL %s: got re=%0d im=%0d idx=%0d last=%b, required re=%0d im=%0d idx=%0d last=%b",
                         name, $signed(if1.out_re_o), $signed(if1.out_im_o), if1.out_idx_o, if1.out_last_o,
                         $signed(e.re), $signed(e.im), e.idx, (e.idx == 2'd3));
            end
`ifdef R4_COLLECT_MAG_EN
            checks++;
            if (if1.out_mag_o !== e.mag) begin
                errors++;
                $display("FAIL %s_mag: got %0d, required %0d", name, if1.out_mag_o, e.mag);
            end
`endif
        end
        beats++;
    endtask

    task automatic test_reset();
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start1 = 1'($urandom); clr1 = 1'($urandom); if1.out_ready_i = 1'($urandom);
            start3 = 1'($urandom); clr3 = 1'($urandom); if3.out_ready_i = 1'($urandom);
            m_re[i] = 4'($urandom); m_im[i] = 4'($urandom);
            step();
            checks++;
            if ({ctrl1, busy1, done1, ovr1, if1.out_valid_o, if1.out_re_o, if1.out_im_o,
                 if1.out_idx_o, if1.out_last_o} !== 18'd0) begin
                errors++;
                $display("FAIL reset_outputs1: got %b, required all zero", {ctrl1, busy1, done1, ovr1,
                         if1.out_valid_o, if1.out_re_o, if1.out_im_o, if1.out_idx_o, if1.out_last_o});
            end
            checks++;
            if ({ctrl3, busy3, done3, ovr3, if3.out_valid_o, if3.out_re_o, if3.out_im_o,
                 if3.out_idx_o, if3.out_last_o} !== 18'd0) begin
                errors++;
                $display("FAIL reset_outputs3: got %b, required all zero", {ctrl3, busy3, done3, ovr3,
                         if3.out_valid_o, if3.out_re_o, if3.out_im_o, if3.out_idx_o, if3.out_last_o});
            end
`ifdef R4_COLLECT_MAG_EN
            checks++;
            if (if1.out_mag_o !== 5'd0) begin
                errors++;
                $display("FAIL reset_mag: got %0d, required 0", if1.out_mag_o);
            end
`endif
        end
        start1 = 1'b0; clr1 = 1'b0; if1.out_ready_i = 1'b0;
        start3 = 1'b0; clr3 = 1'b0; if3.out_ready_i = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        step();
        step();
        checks++;
        if (busy1 !== 1'b0 || if1.out_valid_o !== 1'b0 || ctrl1 !== 3'b000 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy1=%b valid=%b ctrl=%b busy3=%b, required 0 0 000 0",
                     busy1, if1.out_valid_o, ctrl1, busy3);
        end
    endtask

    task automatic test_single_frame();
        int beats = 0;
        int dones = 0;
        load_default();
        if1.out_ready_i = 1'b1;
        push_frame();
        start1 = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step();
            start1 = 1'b0;
            checks++;
            if (ctrl1 !== ctrl_tab[e] || busy1 !== 1'b1 || if1.out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL single_ctrl_edge%0d: got ctrl=%b busy=%b valid=%b, required ctrl=%b busy=1 valid=0",
                         e, ctrl1, busy1, if1.out_valid_o, ctrl_tab[e]);
            end
        end
        step();
        checks++;
        if (if1.out_valid_o !== 1'b1 || ctrl1 !== 3'b000) begin
            errors++;
            $display("FAIL single_valid_edge4: got valid=%b ctrl=%b, required valid=1 ctrl=000",
                     if1.out_valid_o, ctrl1);
        end
        for (int c = 0; c < 8; c++) begin
            if (if1.out_valid_o && if1.out_ready_i) check_beat1("single_beat", beats);
            step();
            if (done1) dones++;
        end
        checks++;
        if (beats != 4 || dones != 1 || busy1 !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL single_summary: got beats=%0d dones=%0d busy=%b left=%0d, required 4 1 0 0",
                     beats, dones, busy1, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        int dones = 0;
        int stalls = 0;
        load_default();
        if1.out_ready_i = 1'b1;
        push_frame();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int c = 0; c < 10 && !if1.out_valid_o; c++) step();
        checks++;
        if (!if1.out_valid_o) begin
            errors++;
            $display("FAIL bp_timeout: got valid=0, required valid=1 within 10 cycles");
        end
        for (int c = 0; c < 14; c++) begin
            if (if1.out_valid_o && if1.out_idx_o == 2'd1 && stalls < 3) begin
                if1.out_ready_i = 1'b0;
                stalls++;
                checks++;
                if (if1.out_re_o !== 4'b1000 || if1.out_im_o !== 4'b0111 || if1.out_idx_o !== 2'd1) begin
                    errors++;
                    $display("FAIL bp_hold: got re=%0d im=%0d idx=%0d, required re=-8 im=7 idx=1",
                             $signed(if1.out_re_o), $signed(if1.out_im_o), if1.out_idx_o);
                end
            end else begin
                if1.out_ready_i = 1'b1;
            end
            if (if1.out_valid_o && if1.out_ready_i) check_beat1("bp_beat", beats);
            step();
            if (done1) dones++;
        end
        if1.out_ready_i = 1'b1;
        checks++;
        if (beats != 4 || stalls != 3 || dones != 1 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL bp_summary: got beats=%0d stalls=%0d dones=%0d left=%0d, required 4 3 1 0",
                     beats, stalls, dones, sb_q.size());
        end
    endtask

    task automatic test_overrun();
        int beats = 0;
        int dones = 0;
        load_default();
        if1.out_ready_i = 1'b1;
        push_frame();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        step();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        checks++;
        if (ovr1 !== 1'b1 || ctrl1 !== 3'b100) begin
            errors++;
            $display("FAIL ovr_set: got overrun=%b ctrl=%b, required overrun=1 ctrl=100", ovr1, ctrl1);
        end
        start1 = 1'b1;
        clr1 = 1'b1;
        step();
        start1 = 1'b0;
        clr1 = 1'b0;
        checks++;
        if (ovr1 !== 1'b1 || if1.out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set_wins: got overrun=%b valid=%b, required overrun=1 valid=1",
                     ovr1, if1.out_valid_o);
        end
        for (int c = 0; c < 4; c++) begin
            check_beat1("ovr_beat", beats);
            if (c == 0) clr1 = 1'b1;
            if (c == 3) begin
                start1 = 1'b1;
                push_frame();
            end
            step();
            clr1 = 1'b0;
            start1 = 1'b0;
            if (c == 0) begin
                checks++;
                if (ovr1 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_clear: got overrun=%b, required 0", ovr1);
                end
            end
        end
        checks++;
        if (done1 !== 1'b1 || ovr1 !== 1'b0 || busy1 !== 1'b1 || if1.out_valid_o !== 1'b0 || ctrl1 !== 3'b000) begin
            errors++;
            $display("FAIL ovr_back_to_back: got done=%b overrun=%b busy=%b valid=%b ctrl=%b, required 1 0 1 0 000",
                     done1, ovr1, busy1, if1.out_valid_o, ctrl1);
        end
        for (int c = 0; c < 10 && !if1.out_valid_o; c++) step();
        for (int c = 0; c < 6; c++) begin
            if (if1.out_valid_o && if1.out_ready_i) check_beat1("b2b_beat", beats);
            step();
            if (done1) dones++;
        end
        checks++;
        if (beats != 8 || dones != 1 || sb_q.size() != 0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_summary: got beats=%0d dones=%0d left=%0d busy=%b, required 8 1 0 0",
                     beats, dones, sb_q.size(), busy1);
        end
    endtask

    task automatic test_mag();
        int beats = 0;
        m_re[0] = -4'sd8; m_im[0] = 4'sd7;
        m_re[1] = -4'sd8; m_im[1] = -4'sd8;
        m_re[2] = 4'sd3;  m_im[2] = -4'sd1;
        m_re[3] = 4'sd0;  m_im[3] = 4'sd5;
        if1.out_ready_i = 1'b1;
        push_frame();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (if1.out_valid_o && if1.out_ready_i) check_beat1("mag_beat", beats);
            step();
        end
        checks++;
        if (beats != 4 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL mag_summary: got beats=%0d left=%0d, required 4 0", beats, sb_q.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        int beats = 0;
        load_default();
        if1.out_ready_i = 1'b1;
        push_frame();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int c = 0; c < 12 && !(if1.out_valid_o && if1.out_idx_o == 2'd2); c++) begin
            if (if1.out_valid_o && if1.out_ready_i) check_beat1("mid_beat", beats);
            step();
        end
        checks++;
        if (!(if1.out_valid_o && if1.out_idx_o == 2'd2)) begin
            errors++;
            $display("FAIL mid_timeout: got valid=%b idx=%0d, required idx2 presented", if1.out_valid_o, if1.out_idx_o);
        end
        if1.out_ready_i = 1'b0;
        #2;
        rst1_n = 1'b0;
        #1;
        checks++;
        if ({ctrl1, busy1, done1, ovr1, if1.out_valid_o, if1.out_re_o, if1.out_im_o,
             if1.out_idx_o, if1.out_last_o} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b, required all zero", {ctrl1, busy1, done1, ovr1,
                     if1.out_valid_o, if1.out_re_o, if1.out_im_o, if1.out_idx_o, if1.out_last_o});
        end
        sb_q.delete();
        @(negedge clk);
        rst1_n = 1'b1;
        step();
        checks++;
        if (busy1 !== 1'b0 || if1.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release: got busy=%b valid=%b, required 0 0", busy1, if1.out_valid_o);
        end
    endtask

    task automatic test_settle3();
        int beats = 0;
        int dones = 0;
        beat_t e;
        load_default();
        if3.out_ready_i = 1'b1;
        push_frame();
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            step();
            checks++;
            if (ctrl3 !== (t < 12 ? ctrl_tab[t / 3] : 3'b000) || if3.out_valid_o !== (t >= 12)) begin
                errors++;
                $display("FAIL s3_edge%0d: got ctrl=%b valid=%b, required ctrl=%b valid=%b", t, ctrl3,
                         if3.out_valid_o, (t < 12 ? ctrl_tab[t / 3] : 3'b000), (t >= 12));
            end
        end
        for (int c = 0; c < 8; c++) begin
            if (if3.out_valid_o && if3.out_ready_i) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL s3_beat: unexpected beat idx=%0d, required no beat", if3.out_idx_o);
                end else begin
                    e = sb_q.pop_front();
                    if (if3.out_re_o !== e.re || if3.out_im_o !== e.im || if3.out_idx_o !== e.idx ||
                        if3.out_last_o !== (e.idx == 2'd3)) begin
                        errors++;
                        $display("FAIL s3_beat: got re=%0d im=%0d idx=%0d last=%b, required re=%0d im=%0d idx=%0d",
                                 $signed(if3.out_re_o), $signed(if3.out_im_o), if3.out_idx_o, if3.out_last_o,
                                 $signed(e.re), $signed(e.im), e.idx);
                    end
                end
                beats++;
            end
            step();
            if (done3) dones++;
        end
        checks++;
        if (beats != 4 || dones != 1 || sb_q.size() != 0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL s3_summary: got beats=%0d dones=%0d left=%0d busy=%b, required 4 1 0 0",
                     beats, dones, sb_q.size(), busy3);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ctrl_tab[0] = 3'b000; ctrl_tab[1] = 3'b001; ctrl_tab[2] = 3'b010; ctrl_tab[3] = 3'b100;
        rst1_n = 1'b0; rst3_n = 1'b0;
        start1 = 1'b0; clr1 = 1'b0; start3 = 1'b0; clr3 = 1'b0;
        if1.out_ready_i = 1'b0; if3.out_ready_i = 1'b0;
        load_default();
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overrun();
        test_mag();
        test_reset_mid_drain();
        test_settle3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
